// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 width codes,
// write-back source encodings and the access FSM state type.
package mem_stage_pkg;

  // funct3 width codes (loads and stores share the low codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // write-back source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // data-memory access FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store byte enables and lane
// replication, plus load lane selection with sign/zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_load_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes: narrow data is replicated so the memory only needs the enables
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    if (!is_load_i) begin
      case (width_i)
        F3_B: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3_H: begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = store_data_i;
        end
      endcase
    end
  end

  // Load lanes: halfwords use a[1] only, so an unaligned LH reads its aligned half
  always_comb begin
    rd_shift = rdata_i >> {addr_lo_i, 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (width_i)
      F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data_o = {24'h0, ld_byte};
      F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data_o = {16'h0, ld_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_top.sv
// MEM pipeline stage: drives the data-memory port, stalls the front of the
// pipe while an access waits, aborts on error/timeout and registers MEM/WB.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses fault
// without touching memory); when undefined, low address bits are ignored
// for alignment.
module mem_stage_top
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  memtoreg_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  width_select_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        stall_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  memtoreg_o,
  output logic        fault_o
);

  // Abort fires in the BUSY cycle whose count reaches TIMEOUT_CYCLES
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        access, misalign, req_live, timeout, stall_int, fault_now;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;
  logic [1:0]  a;

  assign a      = alu_result_i[1:0];
  assign access = (memread_i | memwrite_i) & ~flush_i;

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfword needs a[0]=0, word needs a=00; other codes never trap
  always_comb begin
    misalign = 1'b0;
    if (width_select_i == F3_H || (memread_i && width_select_i == F3_HU))
      misalign = a[0];
    else if (width_select_i == F3_W)
      misalign = (a != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign req_live  = access & ~misalign;
  assign timeout   = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
  assign stall_int = req_live & ~(dmem_ready_i | timeout | dmem_err_i);
  assign fault_now = (req_live & (dmem_err_i | timeout)) | (access & misalign);

  mem_lane_align u_lane (
    .width_i      (width_select_i),
    .addr_lo_i    (a),
    .is_load_i    (memread_i),
    .store_data_i (store_data_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (load_data)
  );

  // Access FSM state and wait counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and memory port; request fields come straight from the frozen
  // EX/MEM inputs so they stay stable for the whole BUSY phase
  always_comb begin
    state_d      = state_q;
    cnt_d        = 8'd0;
    dmem_req_o   = rst_ni & req_live;
    dmem_we_o    = rst_ni & req_live & memwrite_i;
    dmem_addr_o  = {alu_result_i[31:2], 2'b00};
    dmem_be_o    = (rst_ni & req_live) ? lane_be : 4'b0000;
    dmem_wdata_o = (rst_ni & req_live & memwrite_i) ? lane_wdata : 32'h0;
    stall_o      = rst_ni & stall_int;
    case (state_q)
      ST_IDLE: if (stall_int) state_d = ST_BUSY;
      ST_BUSY: begin
        if (stall_int) cnt_d = cnt_q + 8'd1;
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB register: bubble while stalled or flushed, faulted access never writes back
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_result_o <= 32'h0;
      mem_data_o   <= 32'h0;
      regwrite_o   <= 1'b0;
      rd_addr_o    <= 5'd0;
      memtoreg_o   <= WB_ALU;
      fault_o      <= 1'b0;
    end else if (stall_int || flush_i) begin
      alu_result_o <= 32'h0;
      mem_data_o   <= 32'h0;
      regwrite_o   <= 1'b0;
      rd_addr_o    <= 5'd0;
      memtoreg_o   <= WB_ALU;
      fault_o      <= 1'b0;
    end else begin
      alu_result_o <= alu_result_i;
      regwrite_o   <= regwrite_i & ~fault_now;
      rd_addr_o    <= rd_addr_i;
      memtoreg_o   <= memtoreg_i;
      fault_o      <= fault_now;
      if (memtoreg_i == WB_PC4) mem_data_o <= pc_plus4_i;
      else if (memread_i)       mem_data_o <= load_data;
      else                      mem_data_o <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_stage_top.sv
// Directed bench for mem_stage_top (TIMEOUT_CYCLES=4).
module tb_mem_stage_top;
  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic [31:0] alu_result_i, store_data_i, pc_plus4_i;
  logic        regwrite_i, memread_i, memwrite_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  memtoreg_i;
  logic [2:0]  width_select_i;
  logic        dmem_req_o, dmem_we_o, dmem_ready_i, dmem_err_i, stall_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] alu_result_o, mem_data_o;
  logic        regwrite_o, fault_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  memtoreg_o;
  int checks = 0, errors = 0;

  mem_stage_top #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .pc_plus4_i(pc_plus4_i),
    .regwrite_i(regwrite_i), .rd_addr_i(rd_addr_i), .memtoreg_i(memtoreg_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .width_select_i(width_select_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i), .stall_o(stall_o),
    .alu_result_o(alu_result_o), .mem_data_o(mem_data_o), .regwrite_o(regwrite_o),
    .rd_addr_o(rd_addr_o), .memtoreg_o(memtoreg_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_in();
    flush_i = 0; alu_result_i = 0; store_data_i = 0; pc_plus4_i = 0;
    regwrite_i = 0; rd_addr_i = 0; memtoreg_i = 0; memread_i = 0; memwrite_i = 0;
    width_select_i = 0; dmem_ready_i = 0; dmem_rdata_i = 0; dmem_err_i = 0;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic rw, input logic [4:0] rd, input logic [1:0] m2r);
    memread_i = mr; memwrite_i = mw; width_select_i = f3; alu_result_i = addr;
    store_data_i = sd; regwrite_i = rw; rd_addr_i = rd; memtoreg_i = m2r;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    clear_in();
    #2 memread_i = 1; memwrite_i = 1;
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b000) begin
      errors++; $display("FAIL reset_port: req/we/stall=%b want 000", {dmem_req_o, dmem_we_o, stall_o});
    end
    checks++;
    if ({alu_result_o, mem_data_o, regwrite_o, rd_addr_o, memtoreg_o, fault_o} !== 72'h0) begin
      errors++; $display("FAIL reset_regs: alu=%h mem=%h rw=%b rd=%0d m2r=%b f=%b want all 0",
        alu_result_o, mem_data_o, regwrite_o, rd_addr_o, memtoreg_o, fault_o);
    end
    clear_in();
    @(negedge clk_i) rst_ni = 1;
    next_cycle();
  endtask

  task automatic test_sw();
    drive(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 2'b00);
    dmem_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_be_o, stall_o} !== 7'b1111110) begin
      errors++; $display("FAIL sw_ctrl: req/we/be/stall=%b want 1111110", {dmem_req_o, dmem_we_o, dmem_be_o, stall_o});
    end
    checks++;
    if ({dmem_addr_o, dmem_wdata_o} !== {32'h100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_data: addr=%h wdata=%h want 00000100 deadbeef", dmem_addr_o, dmem_wdata_o);
    end
    next_cycle();
    checks++;
    if ({regwrite_o, fault_o, alu_result_o} !== {2'b00, 32'h100}) begin
      errors++; $display("FAIL sw_wb: rw=%b fault=%b alu=%h want 0 0 00000100", regwrite_o, fault_o, alu_result_o);
    end
    clear_in();
  endtask

  task automatic test_lb_wait();
    int stalls = 0, bubbles = 0;
    drive(1, 0, 3'b000, 32'h103, 0, 1, 5'd5, 2'b01);
    dmem_rdata_i = 32'h80FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (stall_o === 1'b1 && dmem_req_o === 1'b1) stalls++;
      next_cycle();
      if (regwrite_o === 1'b0 && rd_addr_o === 5'd0) bubbles++;
    end
    checks++;
    if (stalls != 3 || bubbles != 3) begin
      errors++; $display("FAIL lb_stall: stall cycles=%0d bubbles=%0d want 3 3", stalls, bubbles);
    end
    dmem_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL lb_release: stall=%b want 0", stall_o);
    end
    next_cycle();
    checks++;
    if ({mem_data_o, regwrite_o, rd_addr_o, memtoreg_o} !== {32'hFFFFFF80, 1'b1, 5'd5, 2'b01}) begin
      errors++; $display("FAIL lb_wb: data=%h rw=%b rd=%0d m2r=%b want ffffff80 1 5 01",
        mem_data_o, regwrite_o, rd_addr_o, memtoreg_o);
    end
    clear_in();
  endtask

  task automatic test_lhu();
    drive(1, 0, 3'b101, 32'h102, 0, 1, 5'd6, 2'b01);
    dmem_rdata_i = 32'h8001_0000; dmem_ready_i = 1;
    next_cycle();
    checks++;
    if ({mem_data_o, regwrite_o} !== {32'h00008001, 1'b1}) begin
      errors++; $display("FAIL lhu: data=%h rw=%b want 00008001 1", mem_data_o, regwrite_o);
    end
    drive(1, 0, 3'b001, 32'h102, 0, 1, 5'd6, 2'b01);
    dmem_rdata_i = 32'hFFFE_0000;
    next_cycle();
    checks++;
    if (mem_data_o !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL lh_sext: data=%h want fffffffe", mem_data_o);
    end
    drive(1, 0, 3'b100, 32'h101, 0, 1, 5'd6, 2'b01);
    dmem_rdata_i = 32'h0000_9A00;
    next_cycle();
    checks++;
    if (mem_data_o !== 32'h0000009A) begin
      errors++; $display("FAIL lbu_zext: data=%h want 0000009a", mem_data_o);
    end
    clear_in();
  endtask

  task automatic test_narrow_store();
    dmem_ready_i = 1;
    drive(0, 1, 3'b000, 32'h102, 32'h123456AB, 0, 0, 2'b00);
    @(negedge clk_i);
    checks++;
    if ({dmem_be_o, dmem_wdata_o} !== {4'b0100, 32'hABABABAB}) begin
      errors++; $display("FAIL sb_lane: be=%b wdata=%h want 0100 abababab", dmem_be_o, dmem_wdata_o);
    end
    next_cycle();
    drive(0, 1, 3'b001, 32'h102, 32'hFFFF1234, 0, 0, 2'b00);
    @(negedge clk_i);
    checks++;
    if ({dmem_be_o, dmem_wdata_o} !== {4'b1100, 32'h12341234}) begin
      errors++; $display("FAIL sh_lane: be=%b wdata=%h want 1100 12341234", dmem_be_o, dmem_wdata_o);
    end
    next_cycle();
    clear_in();
  endtask

  task automatic test_jal();
    drive(0, 0, 3'b000, 32'h40, 0, 1, 5'd1, 2'b10);
    pc_plus4_i = 32'h204;
    @(negedge clk_i);
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL jal_port: req/stall=%b want 00", {dmem_req_o, stall_o});
    end
    next_cycle();
    checks++;
    if ({mem_data_o, regwrite_o, rd_addr_o, memtoreg_o} !== {32'h204, 1'b1, 5'd1, 2'b10}) begin
      errors++; $display("FAIL jal_wb: data=%h rw=%b rd=%0d m2r=%b want 00000204 1 1 10",
        mem_data_o, regwrite_o, rd_addr_o, memtoreg_o);
    end
    clear_in();
  endtask

  task automatic test_timeout();
    int stalls = 0, early = 0;
    drive(1, 0, 3'b010, 32'h200, 0, 1, 5'd7, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (stall_o === 1'b1) stalls++;
      next_cycle();
      if (fault_o !== 1'b0) early++;
    end
    checks++;
    if (stalls != 4 || early != 0) begin
      errors++; $display("FAIL to_wait: stall cycles=%0d early faults=%0d want 4 0", stalls, early);
    end
    @(negedge clk_i);
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b01) begin
      errors++; $display("FAIL to_release: stall/req=%b want 01", {stall_o, dmem_req_o});
    end
    next_cycle();
    checks++;
    if ({fault_o, regwrite_o} !== 2'b10) begin
      errors++; $display("FAIL to_fault: fault/rw=%b want 10", {fault_o, regwrite_o});
    end
    clear_in();
    next_cycle();
    checks++;
    if (fault_o !== 1'b0) begin
      errors++; $display("FAIL to_pulse: fault=%b want 0", fault_o);
    end
  endtask

  task automatic test_err();
    drive(1, 0, 3'b010, 32'h400, 0, 1, 5'd8, 2'b01);
    dmem_err_i = 1;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL err_stall: stall=%b want 0", stall_o);
    end
    next_cycle();
    checks++;
    if ({fault_o, regwrite_o} !== 2'b10) begin
      errors++; $display("FAIL err_fault: fault/rw=%b want 10", {fault_o, regwrite_o});
    end
    clear_in();
  endtask

  task automatic test_misalign();
    drive(1, 0, 3'b010, 32'h101, 0, 1, 5'd9, 2'b01);
    dmem_ready_i = 1; dmem_rdata_i = 32'hCAFEBABE;
    @(negedge clk_i);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL mis_port: req/stall=%b want 00", {dmem_req_o, stall_o});
    end
    next_cycle();
    checks++;
    if ({fault_o, regwrite_o} !== 2'b10) begin
      errors++; $display("FAIL mis_fault: fault/rw=%b want 10", {fault_o, regwrite_o});
    end
`else
    checks++;
    if ({dmem_req_o, dmem_addr_o, dmem_be_o} !== {1'b1, 32'h100, 4'b1111}) begin
      errors++; $display("FAIL mis_port: req=%b addr=%h be=%b want 1 00000100 1111", dmem_req_o, dmem_addr_o, dmem_be_o);
    end
    next_cycle();
    checks++;
    if ({mem_data_o, fault_o, regwrite_o} !== {32'hCAFEBABE, 2'b01}) begin
      errors++; $display("FAIL mis_wb: data=%h fault=%b rw=%b want cafebabe 0 1", mem_data_o, fault_o, regwrite_o);
    end
`endif
    clear_in();
  endtask

  task automatic test_flush_reset();
    drive(0, 1, 3'b010, 32'h300, 32'h11223344, 0, 0, 2'b00);
    @(negedge clk_i);
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b11) begin
      errors++; $display("FAIL fl_busy: req/stall=%b want 11", {dmem_req_o, stall_o});
    end
    next_cycle();
    flush_i = 1; dmem_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b000) begin
      errors++; $display("FAIL fl_port: req/we/stall=%b want 000", {dmem_req_o, dmem_we_o, stall_o});
    end
    next_cycle();
    checks++;
    if ({regwrite_o, fault_o, rd_addr_o, memtoreg_o} !== 9'h0) begin
      errors++; $display("FAIL fl_bubble: rw=%b f=%b rd=%0d m2r=%b want 0", regwrite_o, fault_o, rd_addr_o, memtoreg_o);
    end
    flush_i = 0; dmem_ready_i = 0;
    next_cycle();
    #2 rst_ni = 0;
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b000) begin
      errors++; $display("FAIL rst_mid: req/we/stall=%b want 000", {dmem_req_o, dmem_we_o, stall_o});
    end
    clear_in();
    @(negedge clk_i) rst_ni = 1;
    next_cycle();
    checks++;
    if ({dmem_req_o, alu_result_o, mem_data_o, regwrite_o, rd_addr_o, memtoreg_o, fault_o} !== 73'h0) begin
      errors++; $display("FAIL rst_after: req=%b alu=%h mem=%h rw=%b rd=%0d m2r=%b f=%b want all 0",
        dmem_req_o, alu_result_o, mem_data_o, regwrite_o, rd_addr_o, memtoreg_o, fault_o);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_wait();
    test_lhu();
    test_narrow_store();
    test_jal();
    test_timeout();
    test_err();
    test_misalign();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
